// File: rtl/ray_dda_stepper.sv
// ray_dda_stepper: per-ray DDA tile-map walker slaved to the raycaster control FSM.
// Define RAY_DDA_STEP_COUNT_EN to add the hit_steps output.
module ray_dda_stepper #(
  parameter int MAP_BITS  = 4,
  parameter int DIST_W    = 16,
  parameter int SCREEN_W  = 320,
  parameter int COL_W     = 9,
  parameter int MAX_STEPS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            S,
  input  logic                  start,
  input  logic [MAP_BITS-1:0]   start_map_x,
  input  logic [MAP_BITS-1:0]   start_map_y,
  input  logic                  step_x_neg,
  input  logic                  step_y_neg,
  input  logic [DIST_W-1:0]     side_dist_x0,
  input  logic [DIST_W-1:0]     side_dist_y0,
  input  logic [DIST_W-1:0]     delta_dist_x,
  input  logic [DIST_W-1:0]     delta_dist_y,
  output logic [2*MAP_BITS-1:0] map_addr,
  input  logic [3:0]            map_cell,
  output logic                  switch_state,
  output logic [COL_W-1:0]      ray_col,
  output logic                  hit_valid,
  output logic                  hit_side,
  output logic [DIST_W-1:0]     hit_dist,
  output logic [3:0]            hit_cell,
  output logic                  frame_done
`ifdef RAY_DDA_STEP_COUNT_EN
  , output logic [5:0]          hit_steps
`endif
);
  localparam int SC_W = $clog2(MAX_STEPS + 1);
  localparam logic [1:0] S_IDLE = 2'b00, S_FEED = 2'b01, S_PROC = 2'b10, S_DONE = 2'b11;
  typedef enum logic [2:0] {R_IDLE, R_LOAD, R_WAIT, R_STEP, R_FETCH, R_HIT} state_t;
  state_t state, state_n;
  logic [MAP_BITS-1:0] map_x, map_y;
  logic                neg_x, neg_y, side, armed;
  logic [DIST_W-1:0]   sdx, sdy, ddx, ddy, cand;
  logic [SC_W-1:0]     steps;
  logic                abort, x_sel, timeout;
  function automatic logic [DIST_W-1:0] sat_add(input logic [DIST_W-1:0] a, input logic [DIST_W-1:0] b);
    logic [DIST_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DIST_W] ? '1 : s[DIST_W-1:0];
  endfunction
  assign map_addr = {map_y, map_x};
  assign abort    = (S == S_IDLE) || (S == S_DONE);
  assign x_sel    = sdx <= sdy;
  assign timeout  = steps == SC_W'(MAX_STEPS);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= R_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = R_IDLE;
    case (state)
      R_IDLE:  state_n = (S == S_FEED) ? R_LOAD : R_IDLE;
      R_LOAD:  state_n = R_WAIT;
      R_WAIT:  state_n = abort ? R_IDLE : (S == S_PROC) ? R_STEP : R_WAIT;
      R_STEP:  state_n = abort ? R_IDLE : R_FETCH;
      R_FETCH: state_n = abort ? R_IDLE : (map_cell != '0 || timeout) ? R_HIT : R_STEP;
      default: state_n = R_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {map_x, map_y, neg_x, neg_y, side} <= '0;
      {sdx, sdy, ddx, ddy, cand} <= '0;
      steps <= '0;
      armed <= 1'b1;
      switch_state <= 1'b0;
      ray_col <= '0;
      hit_valid <= 1'b0;
      hit_side <= 1'b0;
      hit_dist <= '0;
      hit_cell <= '0;
      frame_done <= 1'b0;
`ifdef RAY_DDA_STEP_COUNT_EN
      hit_steps <= '0;
`endif
    end else begin
      // the start pulse is re-armed only after start has been seen low
      switch_state <= (state == R_IDLE && S == S_IDLE && start && armed) || state_n == R_LOAD || state_n == R_HIT;
      armed <= !start || (armed && !(state == R_IDLE && S == S_IDLE));
      hit_valid <= state_n == R_HIT;
      frame_done <= state_n == R_HIT && ray_col == COL_W'(SCREEN_W - 1);
      if (state == R_IDLE && S == S_FEED) begin
        map_x <= start_map_x;
        map_y <= start_map_y;
        neg_x <= step_x_neg;
        neg_y <= step_y_neg;
        sdx <= side_dist_x0;
        sdy <= side_dist_y0;
        ddx <= delta_dist_x;
        ddy <= delta_dist_y;
        steps <= '0;
      end
      if (state_n == R_FETCH) begin
        cand <= x_sel ? sdx : sdy;
        side <= !x_sel;
        steps <= steps + 1'b1;
        if (x_sel) begin
          map_x <= neg_x ? map_x - 1'b1 : map_x + 1'b1;
          sdx <= sat_add(sdx, ddx);
        end else begin
          map_y <= neg_y ? map_y - 1'b1 : map_y + 1'b1;
          sdy <= sat_add(sdy, ddy);
        end
      end
      if (state_n == R_HIT) begin
        hit_side <= side;
        hit_dist <= (map_cell != '0) ? cand : '1;
        hit_cell <= map_cell;
`ifdef RAY_DDA_STEP_COUNT_EN
        hit_steps <= (32'(steps) > 63) ? 6'd63 : 6'(steps);
`endif
      end
      if (state == R_HIT) ray_col <= (ray_col == COL_W'(SCREEN_W - 1)) ? '0 : ray_col + 1'b1;
    end
endmodule

// File: tb/tb_ray_dda_stepper.sv
// tb_ray_dda_stepper: directed bench; the bench plays the control FSM and the tile map.
module tb_ray_dda_stepper;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, auto_fsm = 1'b1;
  logic [1:0]  S = 2'b00;
  logic [3:0]  start_map_x = '0, start_map_y = '0;
  logic        step_x_neg = 1'b0, step_y_neg = 1'b0;
  logic [15:0] side_dist_x0 = '0, side_dist_y0 = '0, delta_dist_x = '0, delta_dist_y = '0;
  logic [7:0]  map_addr;
  logic [3:0]  map_cell;
  logic        switch_state, hit_valid, hit_side, frame_done, prev_sw = 1'b0;
  logic [8:0]  ray_col;
  logic [15:0] hit_dist;
  logic [3:0]  hit_cell;
  logic [3:0]  map_mem [256];
  int          tests = 0, fails = 0, lat;
`ifdef RAY_DDA_STEP_COUNT_EN
  logic [5:0]  hit_steps;
`endif
  ray_dda_stepper dut (
    .clk(clk), .reset(reset), .S(S), .start(start),
    .start_map_x(start_map_x), .start_map_y(start_map_y),
    .step_x_neg(step_x_neg), .step_y_neg(step_y_neg),
    .side_dist_x0(side_dist_x0), .side_dist_y0(side_dist_y0),
    .delta_dist_x(delta_dist_x), .delta_dist_y(delta_dist_y),
    .map_addr(map_addr), .map_cell(map_cell), .switch_state(switch_state),
    .ray_col(ray_col), .hit_valid(hit_valid), .hit_side(hit_side),
    .hit_dist(hit_dist), .hit_cell(hit_cell), .frame_done(frame_done)
`ifdef RAY_DDA_STEP_COUNT_EN
    , .hit_steps(hit_steps)
`endif
  );
  assign map_cell = map_mem[map_addr];
  always #5 clk = ~clk;
  // control FSM: IDLE->FEED->PROCESS->FEED on each switch_state pulse
  always @(posedge clk)
    if (auto_fsm && switch_state) S <= (S == 2'b01) ? 2'b10 : 2'b01;
  always @(negedge clk) begin
    if (!reset) begin
      tests++;
      assert (!(switch_state && prev_sw)) else begin
        fails++;
        $error("FAIL b2b_switch got 1,1 exp separated pulses");
      end
    end
    prev_sw = switch_state;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic set_ray(input logic [3:0] mx, input logic [3:0] my, input logic nx, input logic ny,
                         input logic [15:0] sx, input logic [15:0] sy, input logic [15:0] dx, input logic [15:0] dy);
    foreach (map_mem[i]) map_mem[i] = 4'd0;
    start_map_x = mx; start_map_y = my; step_x_neg = nx; step_y_neg = ny;
    side_dist_x0 = sx; side_dist_y0 = sy; delta_dist_x = dx; delta_dist_y = dy;
  endtask
  // lat = cycles from the first PROCESS cycle to hit_valid (1 + 2*steps); -1 on timeout
  task automatic wait_hit(output int l);
    int p;
    p = -1;
    l = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (S == 2'b10 && p < 0) p = n;
      if (hit_valid) begin
        l = n - p;
        return;
      end
    end
  endtask
  task automatic wait_process();
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (S == 2'b10) return;
    end
    chk("wait_process_timeout", 32'd0, 32'd1);
  endtask
  initial begin
    int hv, sw;
    set_ray(4'd2, 4'd2, 1'b0, 1'b0, 16'h0080, 16'h0100, 16'h0100, 16'h0100);
    map_mem[8'h23] = 4'd5;
    @(negedge clk);
    chk("rst_switch", 32'(switch_state), 32'd0);
    chk("rst_valid", 32'(hit_valid), 32'd0);
    chk("rst_col", 32'(ray_col), 32'd0);
    chk("rst_addr", 32'(map_addr), 32'd0);
    chk("rst_dist", 32'(hit_dist), 32'd0);
    chk("rst_frame", 32'({hit_side, hit_cell}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("start_pulse", 32'(switch_state), 32'd1);
    @(negedge clk);
    chk("start_no_repeat", 32'(switch_state), 32'd0);
    start = 1'b0;
    wait_hit(lat);
    chk("r1_lat", 32'(lat), 32'd3);
    chk("r1_side", 32'(hit_side), 32'd0);
    chk("r1_dist", 32'(hit_dist), 32'h0080);
    chk("r1_cell", 32'(hit_cell), 32'd5);
    chk("r1_addr", 32'(map_addr), 32'h23);
    chk("r1_col", 32'(ray_col), 32'd0);
    chk("r1_switch", 32'(switch_state), 32'd1);
    set_ray(4'd5, 4'd5, 1'b0, 1'b0, 16'h0200, 16'h0200, 16'h0100, 16'h0100);
    map_mem[8'h56] = 4'd7;
    @(negedge clk);
    chk("r1_col_inc", 32'(ray_col), 32'd1);
    chk("r1_valid_one", 32'(hit_valid), 32'd0);
    wait_hit(lat);
    chk("tie_lat", 32'(lat), 32'd3);
    chk("tie_side", 32'(hit_side), 32'd0);
    chk("tie_dist", 32'(hit_dist), 32'h0200);
    chk("tie_cell", 32'(hit_cell), 32'd7);
    set_ray(4'd8, 4'd8, 1'b0, 1'b1, 16'h1000, 16'h0030, 16'h1000, 16'h0040);
    map_mem[8'h58] = 4'd3;
    wait_hit(lat);
    chk("r3_lat", 32'(lat), 32'd7);
    chk("r3_side", 32'(hit_side), 32'd1);
    chk("r3_dist", 32'(hit_dist), 32'h00B0);
    chk("r3_cell", 32'(hit_cell), 32'd3);
    chk("r3_col", 32'(ray_col), 32'd2);
`ifdef RAY_DDA_STEP_COUNT_EN
    chk("r3_steps", 32'(hit_steps), 32'd3);
`endif
    set_ray(4'd0, 4'd0, 1'b1, 1'b1, 16'h0010, 16'h0018, 16'h0020, 16'h0020);
    wait_hit(lat);
    chk("to_lat", 32'(lat), 32'd65);
    chk("to_cell", 32'(hit_cell), 32'd0);
    chk("to_dist", 32'(hit_dist), 32'hFFFF);
    chk("to_side", 32'(hit_side), 32'd1);
    chk("to_addr_wrap", 32'(map_addr), 32'h00);
    set_ray(4'd0, 4'd0, 1'b0, 1'b0, 16'hFF00, 16'hFFF0, 16'h0200, 16'h0100);
    map_mem[8'h11] = 4'd9;
    wait_hit(lat);
    chk("sat_lat", 32'(lat), 32'd5);
    chk("sat_side", 32'(hit_side), 32'd1);
    chk("sat_dist", 32'(hit_dist), 32'hFFF0);
    chk("sat_col", 32'(ray_col), 32'd4);
    set_ray(4'd0, 4'd0, 1'b0, 1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    wait_process();
    @(negedge clk);
    @(negedge clk);
    S = 2'b00;
    hv = 0;
    sw = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      hv += int'(hit_valid);
      sw += int'(switch_state);
    end
    chk("abort_valid", 32'(hv), 32'd0);
    chk("abort_switch", 32'(sw), 32'd0);
    chk("abort_col", 32'(ray_col), 32'd5);
    S = 2'b01;
    wait_process();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_addr", 32'(map_addr), 32'd0);
    chk("mid_rst_col", 32'(ray_col), 32'd0);
    chk("mid_rst_out", 32'({switch_state, hit_valid, hit_side, hit_cell, frame_done}), 32'd0);
    chk("mid_rst_dist", 32'(hit_dist), 32'd0);
    @(negedge clk);
    S = 2'b00;
    reset = 1'b0;
    set_ray(4'd2, 4'd2, 1'b0, 1'b0, 16'h0080, 16'h0100, 16'h0100, 16'h0100);
    map_mem[8'h23] = 4'd5;
    @(negedge clk);
    S = 2'b01;
    for (int i = 0; i < 320; i++) begin
      wait_hit(lat);
      chk("frame_col", 32'(ray_col), 32'(i));
      chk("frame_done", 32'(frame_done), 32'(i == 319));
    end
    @(negedge clk);
    chk("frame_col_wrap", 32'(ray_col), 32'd0);
    chk("frame_done_one", 32'(frame_done), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ray_dda_stepper.md
Name: ray_dda_stepper

Overview:
- Per-ray DDA grid traversal engine, paired with the raycaster control FSM (IDLE/FEED/PROCESS/DONE).
- Consumes the FSM state code. Latches one ray's setup during FEED and walks the tile map during PROCESS until it hits a wall.
- Drives the FSM's switch_state input with single-cycle pulses that advance FEED->PROCESS and PROCESS->FEED.
- Tracks the screen column and emits the wall hit distance, side and cell code for the column renderer.

Parameters:
- MAP_BITS, 4, bits per map coordinate; map is 2^MAP_BITS x 2^MAP_BITS tiles.
- DIST_W, 16, width of unsigned fixed-point distances (Q8.8 at default).
- SCREEN_W, 320, rays per frame.
- COL_W, 9, column counter width; must satisfy 2^COL_W >= SCREEN_W.
- MAX_STEPS, 32, step limit before a forced miss.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- S  in  2  control FSM state: 00 IDLE, 01 FEED, 10 PROCESS, 11 DONE
- start  in  1  level request to leave IDLE
- start_map_x  in  MAP_BITS  ray origin tile x
- start_map_y  in  MAP_BITS  ray origin tile y
- step_x_neg  in  1  1 = x step is -1, 0 = +1
- step_y_neg  in  1  1 = y step is -1, 0 = +1
- side_dist_x0  in  DIST_W  initial side distance x
- side_dist_y0  in  DIST_W  initial side distance y
- delta_dist_x  in  DIST_W  per-tile distance increment x
- delta_dist_y  in  DIST_W  per-tile distance increment y
- map_addr  out  2*MAP_BITS  {map_y, map_x}, registered
- map_cell  in  4  asynchronous map read of map_addr; 0 = empty
- switch_state  out  1  one-cycle pulse to the control FSM
- ray_col  out  COL_W  column of the current ray
- hit_valid  out  1  one-cycle result strobe
- hit_side  out  1  0 = x-side wall, 1 = y-side wall
- hit_dist  out  DIST_W  perpendicular distance
- hit_cell  out  4  wall cell code; 0 on miss
- frame_done  out  1  one-cycle pulse with the hit of column SCREEN_W-1

Behaviour:
- Reset: all outputs 0, internal state R_IDLE, step counter 0.
- Internal states: R_IDLE, R_LOAD, R_WAIT, R_STEP, R_FETCH, R_HIT.
- R_IDLE, S=IDLE: if start=1, pulse switch_state for one cycle. The pulse does not repeat until start has been seen low.
- R_IDLE, S=FEED: latch all ray inputs and clear the step counter; go to R_LOAD.
- R_LOAD: pulse switch_state; go to R_WAIT.
- R_WAIT: go to R_STEP when S=PROCESS.
- R_STEP: choose the axis.
  - x-axis if side_dist_x <= side_dist_y; a tie steps x.
  - Save the pre-add side_dist of the chosen axis as hit_dist candidate.
  - Update map coordinate by +/-1; coordinates wrap modulo 2^MAP_BITS.
  - side_dist += delta_dist, saturating at all-ones.
  - Register map_addr, increment the step counter, go to R_FETCH.
- R_FETCH:
  - map_cell != 0: register hit_side, hit_dist and hit_cell; go to R_HIT.
  - Else, if step counter = MAX_STEPS: hit_cell=0, hit_dist=all-ones, hit_side=last axis; go to R_HIT.
  - Else go to R_STEP.
- R_HIT:
  - hit_valid=1 and switch_state=1 for exactly one cycle.
  - frame_done=1 if ray_col = SCREEN_W-1.
  - ray_col increments, wrapping to 0 after SCREEN_W-1.
  - Go to R_IDLE, which then waits for S=FEED.
- Latency: with k steps, hit_valid asserts 2k cycles after the first R_STEP cycle.
- switch_state pulses are always separated by at least one low cycle.
- Abort: if S changes to IDLE or DONE while in R_WAIT, R_STEP or R_FETCH, return to R_IDLE. No pulse, no hit_valid, ray_col unchanged.
- Asynchronous reset takes effect immediately in any state, including mid-ray.
- S=DONE never triggers a pulse from this block.

Optional Feature:
- RAY_DDA_STEP_COUNT_EN defined: adds output port hit_steps (6 bits, saturating). It is registered with hit_valid and holds the number of DDA steps taken for that ray.
- Undefined: the port is absent and no extra logic is built. All other behaviour is identical.

Test Plan:
- Ray 1 (single-step hit): reset, start=1 -> one switch_state pulse. FSM in FEED with origin (2,2), +x/+y, side x0=0x0080, side y0=0x0100, delta x=delta y=0x0100, cell (3,2)=5 -> switch_state after load. After PROCESS: hit_valid at first-step+2 with hit_side=0, hit_dist=0x0080, hit_cell=5, ray_col 0->1.
- Tie: side x0 = side y0 = 0x0200, wall at x+1 -> hit_side=0, hit_dist=0x0200.
- Ray 3 (multi-step y): -y direction, delta y=0x0040, wall three tiles above, x never chosen -> hit_valid at first-step+6, hit_side=1, hit_dist = side y0 + 2*0x0040.
- Timeout: empty map, MAX_STEPS=32 -> hit_valid 64 cycles after first step, hit_cell=0, hit_dist=0xFFFF; coordinates wrap with no error.
- Abort/reset: drive S=IDLE during R_FETCH -> no hit_valid, ray_col unchanged. Assert reset mid-ray -> all outputs 0 within the same cycle.
- Frame wrap: run 320 rays -> frame_done only with column 319, ray_col returns to 0, no back-to-back switch_state highs.
